// File: rtl/damage_resolver.sv
// damage_resolver
//   Frame-stage consumer of the battle-front results. Owns HP for 16 friendly
//   slots, 16 enemy slots and the two towers. When the fronts are in contact it
//   applies one exchange of blows per frame. It reports unit kills as one-cycle
//   pulses and tower destruction as sticky towerDown bits.
//
//   Optional feature: define TOWER_REGEN_EN so that a no-contact frame heals
//   each surviving tower by 1 HP, saturating at TOWER_HP.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   Start / Ack / Done              frame handshake (Done high while in DONE)
//   friendlyFront, enemyFront       9-bit front positions, latched on Start
//   unitDamageSelect                friendly attacker/target ([4]=tower, else slot)
//   enemyDamageSelect               enemy attacker/target ([4]=tower, else slot)
//   unitTypes, enemyTypes           packed 2-bit types, slot i = [2i+1:2i]
//   spawnUnit/Idx, spawnEnemy/Idx   load UNIT_HP into a slot (any state)
//   unitKill/Idx, enemyKill/Idx     one-cycle kill pulses with slot index
//   friendlyTowerHP, enemyTowerHP   tower HP
//   towerDown                       [0]=friendly, [1]=enemy tower dead (sticky)
module damage_resolver #(
    parameter int unsigned UNIT_HP   = 8,
    parameter int unsigned TOWER_HP  = 64,
    parameter int unsigned DMG1      = 1,
    parameter int unsigned DMG2      = 2,
    parameter int unsigned DMG3      = 4,
    parameter int unsigned TOWER_DMG = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        Ack,
    input  logic [8:0]  friendlyFront,
    input  logic [8:0]  enemyFront,
    input  logic [4:0]  unitDamageSelect,
    input  logic [4:0]  enemyDamageSelect,
    input  logic [31:0] unitTypes,
    input  logic [31:0] enemyTypes,
    input  logic        spawnUnit,
    input  logic [3:0]  spawnUnitIdx,
    input  logic        spawnEnemy,
    input  logic [3:0]  spawnEnemyIdx,
    output logic        unitKill,
    output logic [3:0]  unitKillIdx,
    output logic        enemyKill,
    output logic [3:0]  enemyKillIdx,
    output logic [7:0]  friendlyTowerHP,
    output logic [7:0]  enemyTowerHP,
    output logic [1:0]  towerDown,
    output logic        Done
);

    localparam logic [7:0] UNIT_HP_V   = 8'(UNIT_HP);
    localparam logic [7:0] TOWER_HP_V  = 8'(TOWER_HP);
    localparam logic [7:0] TOWER_DMG_V = 8'(TOWER_DMG);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        CHECK = 5'b00010,
        APPLY = 5'b00100,
        KILL  = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    state_t     state;
    logic [7:0] unit_hp  [16];
    logic [7:0] enemy_hp [16];
    logic [8:0] f_front, e_front;
    logic [4:0] u_sel, e_sel;
    logic       died_u, died_e;

    function automatic logic [7:0] type_dmg(input logic [1:0] t);
        case (t)
            2'b01:   type_dmg = 8'(DMG1);
            2'b10:   type_dmg = 8'(DMG2);
            2'b11:   type_dmg = 8'(DMG3);
            default: type_dmg = '0;
        endcase
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        sat_sub = (a > b) ? (a - b) : '0;
    endfunction

    logic [7:0] f_dmg, e_dmg, u_old, u_new, e_old, e_new;
    logic       u_dies, e_dies, e_spawn_hit, u_spawn_hit;

    // Damage dealt by each side and the resulting target HP, from the latched selects
    always_comb begin
        f_dmg = u_sel[4] ? TOWER_DMG_V : type_dmg(unitTypes[{u_sel[3:0], 1'b0} +: 2]);
        e_dmg = e_sel[4] ? TOWER_DMG_V : type_dmg(enemyTypes[{e_sel[3:0], 1'b0} +: 2]);
        u_old = u_sel[4] ? friendlyTowerHP : unit_hp[u_sel[3:0]];
        e_old = e_sel[4] ? enemyTowerHP : enemy_hp[e_sel[3:0]];
        u_new = sat_sub(u_old, e_dmg);
        e_new = sat_sub(e_old, f_dmg);
        u_dies = (u_old != '0) && (u_new == '0);
        e_dies = (e_old != '0) && (e_new == '0);
        // A spawn landing on the target in the APPLY cycle overrides the hit
        u_spawn_hit = spawnUnit  && !u_sel[4] && (spawnUnitIdx  == u_sel[3:0]);
        e_spawn_hit = spawnEnemy && !e_sel[4] && (spawnEnemyIdx == e_sel[3:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            for (int unsigned i = 0; i < 16; i++) begin
                unit_hp[i]  <= '0;
                enemy_hp[i] <= '0;
            end
            f_front         <= '0;
            e_front         <= '0;
            u_sel           <= '0;
            e_sel           <= '0;
            died_u          <= 1'b0;
            died_e          <= 1'b0;
            unitKill        <= 1'b0;
            unitKillIdx     <= '0;
            enemyKill       <= 1'b0;
            enemyKillIdx    <= '0;
            friendlyTowerHP <= TOWER_HP_V;
            enemyTowerHP    <= TOWER_HP_V;
            towerDown       <= '0;
            Done            <= 1'b0;
        end else begin
            unitKill  <= 1'b0;
            enemyKill <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        f_front <= friendlyFront;
                        e_front <= enemyFront;
                        u_sel   <= unitDamageSelect;
                        e_sel   <= enemyDamageSelect;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (e_front >= f_front) begin
                        state <= APPLY;
                    end else begin
                        state <= DONE;
                        Done  <= 1'b1;
`ifdef TOWER_REGEN_EN
                        if (!towerDown[0] && (friendlyTowerHP < TOWER_HP_V))
                            friendlyTowerHP <= friendlyTowerHP + 8'd1;
                        if (!towerDown[1] && (enemyTowerHP < TOWER_HP_V))
                            enemyTowerHP <= enemyTowerHP + 8'd1;
`endif
                    end
                end
                APPLY: begin
                    if (e_sel[4]) enemyTowerHP <= e_new;
                    else          enemy_hp[e_sel[3:0]] <= e_new;
                    if (u_sel[4]) friendlyTowerHP <= u_new;
                    else          unit_hp[u_sel[3:0]] <= u_new;
                    died_e <= e_dies && !e_spawn_hit;
                    died_u <= u_dies && !u_spawn_hit;
                    state  <= KILL;
                end
                KILL: begin
                    if (died_e) begin
                        if (e_sel[4]) towerDown[1] <= 1'b1;
                        else begin
                            enemyKill    <= 1'b1;
                            enemyKillIdx <= e_sel[3:0];
                        end
                    end
                    if (died_u) begin
                        if (u_sel[4]) towerDown[0] <= 1'b1;
                        else begin
                            unitKill    <= 1'b1;
                            unitKillIdx <= u_sel[3:0];
                        end
                    end
                    state <= DONE;
                    Done  <= 1'b1;
                end
                DONE: begin
                    if (Ack) begin
                        Done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Spawns come last so they take priority over an APPLY write to the same slot
            if (spawnUnit)  unit_hp[spawnUnitIdx]   <= UNIT_HP_V;
            if (spawnEnemy) enemy_hp[spawnEnemyIdx] <= UNIT_HP_V;
        end
    end

endmodule

// File: tb/tb_damage_resolver.sv
module tb_damage_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start, Ack;
    logic [8:0]  friendlyFront, enemyFront;
    logic [4:0]  unitDamageSelect, enemyDamageSelect;
    logic [31:0] unitTypes, enemyTypes;
    logic        spawnUnit, spawnEnemy;
    logic [3:0]  spawnUnitIdx, spawnEnemyIdx;
    logic        unitKill, enemyKill;
    logic [3:0]  unitKillIdx, enemyKillIdx;
    logic [7:0]  friendlyTowerHP, enemyTowerHP;
    logic [1:0]  towerDown;
    logic        Done;

    damage_resolver dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Ack(Ack),
        .friendlyFront(friendlyFront), .enemyFront(enemyFront),
        .unitDamageSelect(unitDamageSelect), .enemyDamageSelect(enemyDamageSelect),
        .unitTypes(unitTypes), .enemyTypes(enemyTypes),
        .spawnUnit(spawnUnit), .spawnUnitIdx(spawnUnitIdx),
        .spawnEnemy(spawnEnemy), .spawnEnemyIdx(spawnEnemyIdx),
        .unitKill(unitKill), .unitKillIdx(unitKillIdx),
        .enemyKill(enemyKill), .enemyKillIdx(enemyKillIdx),
        .friendlyTowerHP(friendlyTowerHP), .enemyTowerHP(enemyTowerHP),
        .towerDown(towerDown), .Done(Done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state
    int   m_uhp [16];
    int   m_ehp [16];
    int   m_ft, m_et;
    logic [1:0] m_td;

    typedef struct {
        bit contact;
        bit uk;
        int uki;
        bit ek;
        int eki;
        int fth;
        int eth;
        int td;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dmg_of(input logic [1:0] t);
        case (t)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int sub0(input int a, input int b);
        return (a > b) ? a - b : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_uhp[i] = 0;
            m_ehp[i] = 0;
        end
        m_ft = 64;
        m_et = 64;
        m_td = 2'b00;
    endtask

    task automatic spawn(input bit do_u, input int ui, input bit do_e, input int ei);
        spawnUnit = do_u; spawnUnitIdx = 4'(ui);
        spawnEnemy = do_e; spawnEnemyIdx = 4'(ei);
        @(posedge clk); #1;
        spawnUnit = 1'b0; spawnEnemy = 1'b0;
        if (do_u) m_uhp[ui] = 8;
        if (do_e) m_ehp[ei] = 8;
    endtask

    // One full frame: model prediction pushed, then DUT driven, then popped and compared.
    task automatic run_frame(input int ff, input int ef, input logic [4:0] us,
                             input logic [4:0] es, input bit sp_apply, input int sp_idx);
        exp_t e;
        int   cyc, fd, ed, old, nw;
        e = '{default: 0};
        e.contact = (ef >= ff);
        if (!e.contact) begin
`ifdef TOWER_REGEN_EN
            if (!m_td[0] && m_ft < 64) m_ft++;
            if (!m_td[1] && m_et < 64) m_et++;
`endif
        end else begin
            fd = us[4] ? 2 : dmg_of(unitTypes[2*us[3:0] +: 2]);
            ed = es[4] ? 2 : dmg_of(enemyTypes[2*es[3:0] +: 2]);
            if (es[4]) begin
                old = m_et; nw = sub0(old, fd); m_et = nw;
                if (old != 0 && nw == 0) m_td[1] = 1'b1;
            end else begin
                old = m_ehp[es[3:0]]; nw = sub0(old, fd); m_ehp[es[3:0]] = nw;
                if (old != 0 && nw == 0 && !(sp_apply && sp_idx == int'(es[3:0]))) begin
                    e.ek = 1; e.eki = es[3:0];
                end
            end
            if (us[4]) begin
                old = m_ft; nw = sub0(old, ed); m_ft = nw;
                if (old != 0 && nw == 0) m_td[0] = 1'b1;
            end else begin
                old = m_uhp[us[3:0]]; nw = sub0(old, ed); m_uhp[us[3:0]] = nw;
                if (old != 0 && nw == 0) begin
                    e.uk = 1; e.uki = us[3:0];
                end
            end
        end
        if (sp_apply) m_ehp[sp_idx] = 8;
        e.fth = m_ft; e.eth = m_et; e.td = m_td;
        sb.push_back(e);

        friendlyFront = 9'(ff); enemyFront = 9'(ef);
        unitDamageSelect = us; enemyDamageSelect = es;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        cyc = 1;
        while (!Done && cyc < 12) begin
            if (sp_apply) begin
                spawnEnemy = (cyc == 2);
                spawnEnemyIdx = 4'(sp_idx);
            end
            @(posedge clk); #1;
            cyc++;
        end
        spawnEnemy = 1'b0;

        e = sb.pop_front();
        check("latency", cyc, e.contact ? 4 : 2);
        check("done_high", Done, 1);
        check("unit_kill", unitKill, e.uk);
        if (e.uk) check("unit_kill_idx", unitKillIdx, e.uki);
        check("enemy_kill", enemyKill, e.ek);
        if (e.ek) check("enemy_kill_idx", enemyKillIdx, e.eki);
        check("friendly_tower_hp", friendlyTowerHP, e.fth);
        check("enemy_tower_hp", enemyTowerHP, e.eth);
        check("tower_down", towerDown, e.td);

        Ack = 1'b1;
        @(posedge clk); #1;
        Ack = 1'b0;
        check("done_low_after_ack", Done, 0);
        check("unit_kill_one_cycle", unitKill, 0);
        check("enemy_kill_one_cycle", enemyKill, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ftower"}, friendlyTowerHP, 64);
        check({tag, "_etower"}, enemyTowerHP, 64);
        check({tag, "_done"}, Done, 0);
        check({tag, "_tdown"}, towerDown, 0);
        check({tag, "_ukill"}, unitKill, 0);
        check({tag, "_ekill"}, enemyKill, 0);
        check({tag, "_ukidx"}, unitKillIdx, 0);
        check({tag, "_ekidx"}, enemyKillIdx, 0);
    endtask

    initial begin
        rst_n = 1'b0; Start = 1'b0; Ack = 1'b0;
        friendlyFront = '0; enemyFront = '0;
        unitDamageSelect = '0; enemyDamageSelect = '0;
        unitTypes = '0; enemyTypes = '0;
        spawnUnit = 1'b0; spawnUnitIdx = '0; spawnEnemy = 1'b0; spawnEnemyIdx = '0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // No contact: Done after 2 cycles, nothing changes
        run_frame(300, 200, 5'd0, 5'd0, 1'b0, 0);

        // Slot 3 duel: friendly type 3 vs enemy type 1, both spawned in one cycle
        unitTypes[7:6]  = 2'b11;
        enemyTypes[7:6] = 2'b01;
        spawn(1'b1, 3, 1'b1, 3);
        for (int f = 0; f < 3; f++) run_frame(250, 260, 5'd3, 5'd3, 1'b0, 0);

        // Spawn on the enemy slot during the APPLY that would kill it
        spawn(1'b0, 0, 1'b1, 3);
        run_frame(250, 260, 5'd3, 5'd3, 1'b0, 0);
        run_frame(250, 260, 5'd3, 5'd3, 1'b1, 3);
        for (int f = 0; f < 3; f++) run_frame(250, 260, 5'd3, 5'd3, 1'b0, 0);

        // Enemy tower worn down by a type-2 unit; equal fronts count as contact
        unitTypes[11:10] = 2'b10;
        for (int f = 0; f < 33; f++) run_frame(100, 100, 5'd5, 5'b10000, 1'b0, 0);

        // Friendly tower hit by a type-3 enemy, then a no-contact frame
        enemyTypes[1:0] = 2'b11;
        run_frame(10, 400, 5'b10000, 5'd0, 1'b0, 0);
        run_frame(400, 10, 5'b10000, 5'd0, 1'b0, 0);

        // Reset asserted while the frame is in APPLY
        friendlyFront = 9'd10; enemyFront = 9'd20;
        unitDamageSelect = 5'b10000; enemyDamageSelect = 5'd0;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("postreset");
        run_frame(300, 200, 5'd0, 5'd0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
